magnitude_search: RTL



---
 rtl/magnitude_search_pkg.sv | 22 ++
 rtl/magnitude_search_if.sv | 40 ++++
 rtl/magnitude_search_settle_timer.sv | 41 ++++
 rtl/magnitude_search.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/magnitude_search_pkg.sv
// -----------------------------------------------------------------------------
// magnitude_search_pkg
// Shared types and helpers for the successive-approximation magnitude search.
//   state_t  : search FSM states (IDLE, EVAL, DONE)
//   SETTLE_W : width of the settle-wait counter (SETTLE range 0..15)
//   onehot3  : true when exactly one bit of a 3-bit verdict is set
// -----------------------------------------------------------------------------
package magnitude_search_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/magnitude_search_if.sv
// -----------------------------------------------------------------------------
// magnitude_search_if
// Bundles the search engine's request/verdict inputs and its trial/result
// outputs. Signal prefixes are from the engine's point of view.
//   i_start  : request a search
//   i_equal  : comparator verdict A == Guess
//   i_biga   : comparator verdict A > Guess
//   i_bigb   : comparator verdict Guess > A
//   o_guess  : trial value driving the comparator B operand
//   o_busy   : search in progress
//   o_done   : one-cycle completion pulse
//   o_result : recovered value
//   o_fault  : verdict was not one-hot
// Modports: master = the search engine, slave = its environment.
// -----------------------------------------------------------------------------
interface magnitude_search_if #(
  parameter int WIDTH = 4
);

  logic             i_start;
  logic             i_equal;
  logic             i_biga;
  logic             i_bigb;
  logic [WIDTH-1:0] o_guess;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_fault;

  modport master (
    input  i_start, i_equal, i_biga, i_bigb,
    output o_guess, o_busy, o_done, o_result, o_fault
  );

  modport slave (
    output i_start, i_equal, i_biga, i_bigb,
    input  o_guess, o_busy, o_done, o_result, o_fault
  );

endinterface

// File: rtl/magnitude_search_settle_timer.sv
// -----------------------------------------------------------------------------
// magnitude_search_settle_timer
// Counts wait cycles after each Guess update so the verdict is sampled only
// once a slow compare path has settled.
//   i_clk     : rising-edge clock
//   i_rst_n   : asynchronous active-low reset
//   i_load    : restart the wait (count <- 0); has priority over i_inc
//   i_inc     : advance the wait by one cycle
//   o_expired : SETTLE wait cycles have elapsed, verdict may be sampled
// -----------------------------------------------------------------------------
module magnitude_search_settle_timer
  import magnitude_search_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);

  logic [SETTLE_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + SETTLE_W'(1);
    end
  end

  // The count is reloaded after every sample, so it never passes SETTLE and
  // an equality test is sufficient (and trivially true when SETTLE is 0).
  assign o_expired = (r_count == SETTLE_L);

endmodule

// File: rtl/magnitude_search.sv
// -----------------------------------------------------------------------------
// magnitude_search
// Successive-approximation search: drives a trial value onto the B operand of
// an external magnitude comparator and uses its Equal/BigA/BigB verdict to
// resolve the unknown A operand one bit per evaluation, MSB first, exiting
// early on Equal. A non-one-hot verdict aborts the search and raises Fault.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : magnitude_search_if.master (start, verdict in; guess, busy,
//             done, result, fault out)
// Parameters: WIDTH operand width, SETTLE extra wait cycles per evaluation.
// -----------------------------------------------------------------------------
module magnitude_search
  import magnitude_search_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  magnitude_search_if.master   bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] GUESS_MSB = WIDTH'(1) << (WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_guess;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_index;
  logic             r_fault;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_guess_next;
  logic [WIDTH-1:0] w_result_next;
  logic [IDX_W-1:0] w_index_next;
  logic             w_fault_next;

  logic [WIDTH-1:0] w_guess_adj;
  logic [IDX_W-1:0] w_index_dn;
  logic [2:0]       w_verdict;
  logic             w_timer_load;
  logic             w_timer_inc;
  logic             w_settled;

  assign w_verdict  = {bus.i_equal, bus.i_biga, bus.i_bigb};
  assign w_index_dn = r_index - IDX_W'(1);

  magnitude_search_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_timer_load),
    .i_inc     (w_timer_inc),
    .o_expired (w_settled)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_guess  <= '0;
      r_result <= '0;
      r_index  <= IDX_MSB;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_guess  <= w_guess_next;
      r_result <= w_result_next;
      r_index  <= w_index_next;
      r_fault  <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_guess_next  = r_guess;
    w_result_next = r_result;
    w_index_next  = r_index;
    w_fault_next  = r_fault;
    w_timer_load  = 1'b0;
    w_timer_inc   = 1'b0;

    // Current guess with the bit under test resolved by a BigA/BigB verdict:
    // BigB means the guess overshoots A, so that bit must be 0.
    w_guess_adj = r_guess;
    if (bus.i_bigb) begin
      w_guess_adj[r_index] = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_guess_next  = GUESS_MSB;
          w_index_next  = IDX_MSB;
          w_fault_next  = 1'b0;
          w_timer_load  = 1'b1;
          w_state_next  = EVAL;
        end
      end

      EVAL: begin
        if (!w_settled) begin
          w_timer_inc = 1'b1;
        end else if (!onehot3(w_verdict)) begin
          w_fault_next = 1'b1;
          w_state_next = DONE;
        end else if (bus.i_equal) begin
          w_result_next = r_guess;
          w_state_next  = DONE;
        end else if (r_index == '0) begin
          w_guess_next  = w_guess_adj;
          w_result_next = w_guess_adj;
          w_state_next  = DONE;
        end else begin
          // Resolve this bit and trial-set the next lower one.
          w_guess_next             = w_guess_adj;
          w_guess_next[w_index_dn] = 1'b1;
          w_index_next             = w_index_dn;
          w_timer_load             = 1'b1;
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.o_guess  = r_guess;
  assign bus.o_result = r_result;
  assign bus.o_fault  = r_fault;
  assign bus.o_busy   = (r_state != IDLE);
  assign bus.o_done   = (r_state == DONE);

endmodule
